uart_dbus_periph: RTL

- Memory-mapped UART slave on the RV32I core data bus, downstream of the core's addr/dataBusOut/wrEn/rdEn/RamMode/dataBusIn/dataBusInEn port set.
- Selected by the address decoder when bus ID = UART (1).
- Provides TX and RX byte FIFOs, an 8N1 serial engine and a programmable baud divisor.
- Returns load data with the fixed 2-cycle latency the core's WB stage expects.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_dbus_periph_fifo.sv | 57 +++++
 rtl/uart_dbus_periph.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and FSM state type for the UART bus slave.
// UART_RX_IRQ_EN widens the register window so CTRL at 0x10 becomes reachable.
package uart_pkg;

`ifdef UART_RX_IRQ_EN
    localparam int ADDR_W = 6;
`else
    localparam int ADDR_W = 4;
`endif

    localparam logic [7:0] UART_TXDATA = 8'h00;
    localparam logic [7:0] UART_RXDATA = 8'h04;
    localparam logic [7:0] UART_STATUS = 8'h08;
    localparam logic [7:0] UART_DIV    = 8'h0C;
    localparam logic [7:0] UART_CTRL   = 8'h10;

    localparam int ST_TX_EMPTY    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_RX_EMPTY    = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_TX_BUSY     = 4;
    localparam int ST_RX_OVERRUN  = 5;
    localparam int ST_FRAME_ERR   = 6;
    localparam int ST_TX_OVERFLOW = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic logic [15:0] clampDiv(input logic [15:0] v, input logic [15:0] minV);
        return (v < minV) ? minV : v;
    endfunction

endpackage

// File: rtl/uart_dbus_periph_fifo.sv
// Synchronous FIFO with show-ahead output; push and pop may coincide in any state,
// but a pop on an empty FIFO is ignored (no pass-through).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstB,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign dout   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_dbus_periph.sv
// Memory-mapped 8N1 UART slave on the core data bus with TX/RX FIFOs and a 2-cycle load path.
// Optional UART_RX_IRQ_EN adds the CTRL register and a registered irq output.
//
// state | meaning (shared by TX and RX FSMs)
// IDLE  | line idle; TX waits for FIFO data, RX waits for a synced falling edge
// START | start bit; TX drives 0 for DIV clocks, RX re-checks the line at DIV/2
// DATA  | 8 data bits LSB first, one per DIV clocks
// STOP  | stop bit; TX drives 1, RX samples and pushes or flags a framing error
module uart_dbus_periph
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RST    = 868,
    parameter int DIV_MIN    = 4
) (
    input  logic              clk,
    input  logic              rstB,
    input  logic              clkEn,
    input  logic              sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wrData,
    input  logic              wrEn,
    input  logic              rdEn,
    input  logic [3:0]        RamMode,
    output logic [31:0]       rdData,
    output logic              rdDataEn,
`ifdef UART_RX_IRQ_EN
    output logic              irq,
`endif
    output logic              txd,
    input  logic              rxd
);

    logic        acc, wrAcc, rdAcc;
    logic        isTx, isRx, isStat, isDiv, isCtrl;
    logic [15:0] divReg;
    logic        rxOverrun, frameErr, txOverflow;
    logic [7:0]  statusVal;
    logic [31:0] rdVal, rdD1;
    logic        rdV1;
    logic [2:0]  w1c;
    logic [1:0]  ctrlReg;

    logic        txPush, txPop, txFull, txEmpty;
    logic [7:0]  txDout;
    logic        rxPush, rxPop, rxFull, rxEmpty;
    logic [7:0]  rxDout;

    uart_state_t txState, txStateNxt;
    logic [15:0] txCnt, txCntNxt, txDiv, txDivNxt;
    logic [2:0]  txBit, txBitNxt;
    logic [7:0]  txSh, txShNxt;
    logic        txdNxt, txBusy;

    uart_state_t rxState, rxStateNxt;
    logic [15:0] rxCnt, rxCntNxt, rxDiv, rxDivNxt;
    logic [2:0]  rxBit, rxBitNxt;
    logic [7:0]  rxSh, rxShNxt;
    logic        rxS1, rxS2, rxPrev, rxFall, feSet;

    logic        unusedBits;

    assign acc   = sel & clkEn & (wrEn | rdEn);
    assign wrAcc = acc & wrEn;
    assign rdAcc = acc & rdEn & ~wrEn;

    always_comb begin
        isTx   = 1'b0;
        isRx   = 1'b0;
        isStat = 1'b0;
        isDiv  = 1'b0;
        isCtrl = 1'b0;
`ifdef UART_RX_IRQ_EN
        if (addr[5:2] == UART_CTRL[5:2]) begin
            isCtrl = 1'b1;
        end else begin
`else
        begin
`endif
            case (addr[3:2])
                UART_TXDATA[3:2]: isTx   = 1'b1;
                UART_RXDATA[3:2]: isRx   = 1'b1;
                UART_STATUS[3:2]: isStat = 1'b1;
                default:          isDiv  = 1'b1;
            endcase
        end
    end

`ifdef UART_RX_IRQ_EN
    assign unusedBits = ^{RamMode, wrData[31:16], addr[1:0]};
`else
    assign unusedBits = ^{RamMode, wrData[31:16], addr[1:0], isCtrl, ctrlReg};
`endif

    assign txPush = wrAcc & isTx;
    assign rxPop  = rdAcc & isRx & ~rxEmpty;
    assign w1c    = (wrAcc & isStat) ? wrData[ST_TX_OVERFLOW:ST_RX_OVERRUN] : 3'b000;
    assign txBusy = (txState != IDLE);

    always_comb begin
        statusVal                 = '0;
        statusVal[ST_TX_EMPTY]    = txEmpty;
        statusVal[ST_TX_FULL]     = txFull;
        statusVal[ST_RX_EMPTY]    = rxEmpty;
        statusVal[ST_RX_FULL]     = rxFull;
        statusVal[ST_TX_BUSY]     = txBusy;
        statusVal[ST_RX_OVERRUN]  = rxOverrun;
        statusVal[ST_FRAME_ERR]   = frameErr;
        statusVal[ST_TX_OVERFLOW] = txOverflow;
    end

    always_comb begin
        rdVal = '0;
        if (isRx && !rxEmpty) begin
            rdVal = {23'b0, 1'b1, rxDout};
        end else if (isStat) begin
            rdVal = {24'b0, statusVal};
        end else if (isDiv) begin
            rdVal = {16'b0, divReg};
        end else if (isCtrl) begin
            rdVal = {30'b0, ctrlReg};
        end
    end

    // Two register stages give the fixed load latency; data is forced to 0 when not valid.
    always_ff @(posedge clk) begin
        if (!rstB) begin
            rdV1     <= 1'b0;
            rdD1     <= '0;
            rdDataEn <= 1'b0;
            rdData   <= '0;
        end else begin
            rdV1     <= rdAcc;
            rdD1     <= rdAcc ? rdVal : 32'd0;
            rdDataEn <= rdV1;
            rdData   <= rdV1 ? rdD1 : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            divReg     <= 16'(DIV_RST);
            rxOverrun  <= 1'b0;
            frameErr   <= 1'b0;
            txOverflow <= 1'b0;
        end else begin
            if (wrAcc && isDiv) begin
                divReg <= clampDiv(wrData[15:0], 16'(DIV_MIN));
            end
            rxOverrun  <= (rxOverrun  & ~w1c[0]) | (rxPush & rxFull & ~rxPop);
            frameErr   <= (frameErr   & ~w1c[1]) | feSet;
            txOverflow <= (txOverflow & ~w1c[2]) | (txPush & txFull & ~txPop);
        end
    end

`ifdef UART_RX_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rstB) begin
            ctrlReg <= 2'b00;
            irq     <= 1'b0;
        end else begin
            if (wrAcc && isCtrl) begin
                ctrlReg <= wrData[1:0];
            end
            irq <= (ctrlReg[0] & ~rxEmpty) | (ctrlReg[1] & (rxOverrun | frameErr));
        end
    end
`else
    assign ctrlReg = 2'b00;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uTxFifo (
        .clk   (clk),
        .rstB  (rstB),
        .push  (txPush),
        .pop   (txPop),
        .din   (wrData[7:0]),
        .dout  (txDout),
        .full  (txFull),
        .empty (txEmpty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uRxFifo (
        .clk   (clk),
        .rstB  (rstB),
        .push  (rxPush),
        .pop   (rxPop),
        .din   (rxSh),
        .dout  (rxDout),
        .full  (rxFull),
        .empty (rxEmpty)
    );

    // TX: the divisor is latched per frame so a DIV write only affects the next frame.
    always_comb begin
        txStateNxt = txState;
        txCntNxt   = txCnt;
        txDivNxt   = txDiv;
        txBitNxt   = txBit;
        txShNxt    = txSh;
        txPop      = 1'b0;
        case (txState)
            IDLE: begin
                if (!txEmpty) begin
                    txPop      = 1'b1;
                    txShNxt    = txDout;
                    txDivNxt   = divReg;
                    txCntNxt   = divReg - 16'd1;
                    txStateNxt = START;
                end
            end
            START: begin
                if (txCnt == 16'd0) begin
                    txStateNxt = DATA;
                    txCntNxt   = txDiv - 16'd1;
                    txBitNxt   = 3'd0;
                end else begin
                    txCntNxt = txCnt - 16'd1;
                end
            end
            DATA: begin
                if (txCnt == 16'd0) begin
                    txCntNxt = txDiv - 16'd1;
                    if (txBit == 3'd7) begin
                        txStateNxt = STOP;
                    end else begin
                        txBitNxt = txBit + 3'd1;
                        txShNxt  = {1'b0, txSh[7:1]};
                    end
                end else begin
                    txCntNxt = txCnt - 16'd1;
                end
            end
            STOP: begin
                if (txCnt == 16'd0) begin
                    if (!txEmpty) begin
                        txPop      = 1'b1;
                        txShNxt    = txDout;
                        txDivNxt   = divReg;
                        txCntNxt   = divReg - 16'd1;
                        txStateNxt = START;
                    end else begin
                        txStateNxt = IDLE;
                    end
                end else begin
                    txCntNxt = txCnt - 16'd1;
                end
            end
            default: txStateNxt = IDLE;
        endcase
        case (txStateNxt)
            START:   txdNxt = 1'b0;
            DATA:    txdNxt = txShNxt[0];
            default: txdNxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            txState <= IDLE;
            txCnt   <= '0;
            txDiv   <= '0;
            txBit   <= '0;
            txSh    <= '0;
            txd     <= 1'b1;
        end else begin
            txState <= txStateNxt;
            txCnt   <= txCntNxt;
            txDiv   <= txDivNxt;
            txBit   <= txBitNxt;
            txSh    <= txShNxt;
            txd     <= txdNxt;
        end
    end

    assign rxFall = rxPrev & ~rxS2;

    always_comb begin
        rxStateNxt = rxState;
        rxCntNxt   = rxCnt;
        rxDivNxt   = rxDiv;
        rxBitNxt   = rxBit;
        rxShNxt    = rxSh;
        rxPush     = 1'b0;
        feSet      = 1'b0;
        case (rxState)
            IDLE: begin
                if (rxFall) begin
                    rxStateNxt = START;
                    rxDivNxt   = divReg;
                    rxCntNxt   = (divReg >> 1) - 16'd1;
                end
            end
            START: begin
                if (rxCnt == 16'd0) begin
                    if (!rxS2) begin
                        rxStateNxt = DATA;
                        rxCntNxt   = rxDiv - 16'd1;
                        rxBitNxt   = 3'd0;
                    end else begin
                        rxStateNxt = IDLE;
                    end
                end else begin
                    rxCntNxt = rxCnt - 16'd1;
                end
            end
            DATA: begin
                if (rxCnt == 16'd0) begin
                    rxShNxt  = {rxS2, rxSh[7:1]};
                    rxCntNxt = rxDiv - 16'd1;
                    if (rxBit == 3'd7) begin
                        rxStateNxt = STOP;
                    end else begin
                        rxBitNxt = rxBit + 3'd1;
                    end
                end else begin
                    rxCntNxt = rxCnt - 16'd1;
                end
            end
            STOP: begin
                if (rxCnt == 16'd0) begin
                    rxStateNxt = IDLE;
                    rxPush     = rxS2;
                    feSet      = ~rxS2;
                end else begin
                    rxCntNxt = rxCnt - 16'd1;
                end
            end
            default: rxStateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            rxS1    <= 1'b1;
            rxS2    <= 1'b1;
            rxPrev  <= 1'b1;
            rxState <= IDLE;
            rxCnt   <= '0;
            rxDiv   <= '0;
            rxBit   <= '0;
            rxSh    <= '0;
        end else begin
            rxS1    <= rxd;
            rxS2    <= rxS1;
            rxPrev  <= rxS2;
            rxState <= rxStateNxt;
            rxCnt   <= rxCntNxt;
            rxDiv   <= rxDivNxt;
            rxBit   <= rxBitNxt;
            rxSh    <= rxShNxt;
        end
    end

endmodule
